// File: rtl/eth_switch_pkg.sv
// Shared constants and types for the 4-port switch.
package eth_switch_pkg;

  localparam int unsigned NUM_OF_PORTS    = 4;
  localparam int unsigned DATA_IN_SIZE    = 8;
  localparam int unsigned ARB_PTR_W       = $clog2(NUM_OF_PORTS);

  // Egress arbiter timing and guard limits
  localparam int unsigned IFG_CYCLES      = 12;
  localparam int unsigned MAX_FRAME_BYTES = 1522;
  localparam int unsigned STALL_TIMEOUT   = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module eth_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PtrW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PtrW-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               found
);

  logic [PtrW-1:0] cand;

  // Walk candidates from ptr upward, wrapping at NUM_REQ, and keep the first hit
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = ptr;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && (cand == PtrW'(i)) && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
      cand = (cand == PtrW'(NUM_REQ - 1)) ? '0 : cand + PtrW'(1);
    end
  end

endmodule

// File: rtl/eth_out_port_arbiter.sv
// Per-output-port frame scheduler: frame-granular round robin over the ingress
// FIFOs, with inter-frame gap, oversize truncation and stalled-source abort.
module eth_out_port_arbiter
  import eth_switch_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = eth_switch_pkg::NUM_OF_PORTS,
  parameter int unsigned DATA_W          = eth_switch_pkg::DATA_IN_SIZE,
  parameter int unsigned IFG_CYCLES      = eth_switch_pkg::IFG_CYCLES,
  parameter int unsigned MAX_FRAME_BYTES = eth_switch_pkg::MAX_FRAME_BYTES,
  parameter int unsigned STALL_TIMEOUT   = eth_switch_pkg::STALL_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data_i,
  input  logic [NUM_PORTS-1:0]        in_valid_i,
  input  logic [NUM_PORTS-1:0]        in_last_i,
  output logic [NUM_PORTS-1:0]        in_ready_o,
  output logic [DATA_W-1:0]           out_data_o,
  output logic                        out_valid_o,
  output logic                        out_last_o,
  input  logic                        out_ready_i,
  output logic [NUM_PORTS-1:0]        grant_o,
  output logic                        busy_o,
  output logic                        oversize_o,
  output logic                        timeout_o
);

  localparam int unsigned PtrW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CntW   = $clog2(MAX_FRAME_BYTES + 1);
  localparam int unsigned StallW = $clog2(STALL_TIMEOUT + 1);
  localparam int unsigned GapW   = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [CntW-1:0]   LastBeat  = CntW'(MAX_FRAME_BYTES - 1);
  localparam logic [StallW-1:0] StallLast = StallW'(STALL_TIMEOUT - 1);
  localparam logic [GapW-1:0]   GapLast   = GapW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  arb_state_t           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PtrW-1:0]      gidx_q, gidx_d;
  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [StallW-1:0]    stall_q, stall_d;
  logic [GapW-1:0]      gap_q, gap_d;

  logic [NUM_PORTS-1:0] pick_grant;
  logic                 pick_found;
  logic [PtrW-1:0]      pick_idx;
  logic [PtrW-1:0]      next_ptr;
  logic [DATA_W-1:0]    sel_data;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 at_max;
  logic                 beat_xfer;
  logic                 beat_drain;
  logic                 stall_expired;
  logic                 release_frame;

  eth_rr_pick #(
    .NUM_REQ (NUM_PORTS)
  ) u_rr_pick (
    .req   (req_i),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .found (pick_found)
  );

  // One-hot pick to index, and source mux for the current owner
  always_comb begin
    pick_idx  = '0;
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (pick_grant[i]) pick_idx = PtrW'(i);
      if (gidx_q == PtrW'(i)) begin
        sel_data  = in_data_i[i*DATA_W +: DATA_W];
        sel_valid = in_valid_i[i];
        sel_last  = in_last_i[i];
      end
    end
  end

  assign next_ptr      = (gidx_q == PtrW'(NUM_PORTS - 1)) ? '0 : gidx_q + PtrW'(1);
  assign at_max        = (byte_cnt_q == LastBeat);
  assign beat_xfer     = (state_q == XFER) && sel_valid && out_ready_i;
  assign beat_drain    = (state_q == DRAIN) && sel_valid;
  assign stall_expired = (state_q == XFER) && !sel_valid && (stall_q == StallLast);

  // Egress passthrough in XFER; DRAIN pops the owner with egress held invalid
  always_comb begin
    out_data_o  = '0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    in_ready_o  = '0;
    unique case (state_q)
      XFER: begin
        out_data_o  = sel_data;
        out_valid_o = sel_valid;
        out_last_o  = sel_last | at_max;
        in_ready_o  = grant_q & {NUM_PORTS{out_ready_i}};
      end
      DRAIN:   in_ready_o = grant_q;
      default: ;
    endcase
  end

  assign grant_o    = grant_q;
  assign busy_o     = (state_q != IDLE);
  assign oversize_o = beat_xfer && at_max && !sel_last;
  assign timeout_o  = stall_expired;

  // Next-state: arbitration, frame tracking, stall timer and gap counter
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    rr_ptr_d      = rr_ptr_q;
    byte_cnt_d    = byte_cnt_q;
    stall_d       = stall_q;
    gap_d         = gap_q;
    release_frame = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = XFER;
          grant_d    = pick_grant;
          gidx_d     = pick_idx;
          byte_cnt_d = '0;
          stall_d    = '0;
        end
      end
      XFER: begin
        if (beat_xfer) begin
          byte_cnt_d = byte_cnt_q + CntW'(1);
          stall_d    = '0;
          if (sel_last)    release_frame = 1'b1;
          else if (at_max) state_d = DRAIN;
        end else if (!sel_valid) begin
          // Backpressure with valid data holds the timer; only a silent source counts
          if (stall_expired) release_frame = 1'b1;
          else               stall_d = stall_q + StallW'(1);
        end
      end
      DRAIN: begin
        if (beat_drain && sel_last) release_frame = 1'b1;
      end
      GAP: begin
        if (gap_q == GapLast) state_d = IDLE;
        else                  gap_d = gap_q + GapW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (release_frame) begin
      grant_d  = '0;
      rr_ptr_d = next_ptr;
      gap_d    = '0;
      state_d  = (IFG_CYCLES == 0) ? IDLE : GAP;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      stall_q    <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      stall_q    <= stall_d;
      gap_q      <= gap_d;
    end
  end

endmodule

// File: tb/tb_eth_out_port_arbiter.sv
// Scoreboard bench for eth_out_port_arbiter: sources are byte queues, expected
// egress beats are queued at load time and checked by a monitor process.
module tb_eth_out_port_arbiter;

  localparam int NP   = 4;
  localparam int DW   = 8;
  localparam int IFG  = 12;
  localparam int MAXB = 1522;
  localparam int TO   = 1024;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP-1:0]   req_i;
  logic [NP*DW-1:0] in_data_i;
  logic [NP-1:0]   in_valid_i;
  logic [NP-1:0]   in_last_i;
  logic [NP-1:0]   in_ready_o;
  logic [DW-1:0]   out_data_o;
  logic            out_valid_o;
  logic            out_last_o;
  logic            out_ready_i;
  logic [NP-1:0]   grant_o;
  logic            busy_o;
  logic            oversize_o;
  logic            timeout_o;

  eth_out_port_arbiter #(
    .NUM_PORTS       (NP),
    .DATA_W          (DW),
    .IFG_CYCLES      (IFG),
    .MAX_FRAME_BYTES (MAXB),
    .STALL_TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_last_i   (in_last_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_last_o  (out_last_o),
    .out_ready_i (out_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .oversize_o  (oversize_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  logic [8:0]    src_q [NP][$];
  logic [8:0]    exp_q [$];
  logic [NP-1:0] g_log [$];
  int            g_cyc [$];
  int            gap_log [$];
  logic [NP-1:0] hold_v;
  logic [NP-1:0] prev_g;
  logic [NP-1:0] req_prev;
  logic          tog_mode;
  int n_vec, n_err, cyc, beats, ov_cnt, to_cnt, to_cyc, drain_pops, req_cyc, gap_run;

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
    end
  endtask

  // Queue a frame into source s; optionally queue the egress beats it should produce
  task automatic load(input int s, input int len, input int tag, input bit push);
    logic [7:0] d;
    logic       l;
    for (int k = 0; k < len; k++) begin
      d = 8'((s << 6) ^ k ^ tag);
      l = (k == len - 1);
      src_q[s].push_back({l, d});
      if (push && k < MAXB) exp_q.push_back({l || (k == MAXB - 1), d});
    end
  endtask

  function automatic bit srcs_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NP; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Drives sources at negedge, samples handshakes and checks beats just before posedge
  task automatic bus();
    logic [NP-1:0] hs;
    logic [8:0]    e;
    hs = '0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NP; i++)
        if (rst_n && hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      for (int i = 0; i < NP; i++) begin
        req_i[i]      = (src_q[i].size() > 0);
        in_valid_i[i] = (src_q[i].size() > 0) && !hold_v[i];
        if (src_q[i].size() > 0) {in_last_i[i], in_data_i[i*DW +: DW]} = src_q[i][0];
        else                     {in_last_i[i], in_data_i[i*DW +: DW]} = '0;
      end
      if (req_i != '0 && req_prev == '0) req_cyc = cyc;
      req_prev    = req_i;
      out_ready_i = tog_mode ? ((cyc % 2) == 0) : 1'b1;
      #4;
      hs = '0;
      if (rst_n) begin
        if (out_valid_o && out_ready_i) begin
          beats++;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL beat: got unexpected last=%b data=%h, required no beat",
                     out_last_o, out_data_o);
          end else begin
            e = exp_q.pop_front();
            if ({out_last_o, out_data_o} !== e) begin
              n_err++;
              $display("FAIL beat %0d: got last=%b data=%h, required last=%b data=%h",
                       beats, out_last_o, out_data_o, e[8], e[7:0]);
            end
          end
        end
        if (oversize_o) ov_cnt++;
        if (timeout_o) begin
          to_cnt++;
          to_cyc = cyc;
        end
        if (grant_o != '0 && prev_g == '0) begin
          g_log.push_back(grant_o);
          g_cyc.push_back(cyc);
        end
        prev_g = grant_o;
        if (busy_o && grant_o == '0) gap_run++;
        else if (gap_run != 0) begin
          gap_log.push_back(gap_run);
          gap_run = 0;
        end
        for (int i = 0; i < NP; i++)
          if (in_valid_i[i] && in_ready_o[i] && !out_valid_o) drain_pops++;
        hs = in_valid_i & in_ready_o;
      end else begin
        prev_g = '0;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < NP; i++) src_q[i].delete();
    exp_q.delete();
    g_log.delete();
    g_cyc.delete();
    gap_log.delete();
    ov_cnt = 0; to_cnt = 0; to_cyc = 0; drain_pops = 0; beats = 0; gap_run = 0;
    req_cyc = 0; prev_g = '0; hold_v = '0; tog_mode = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && srcs_empty() && !busy_o) && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    if (k >= budget) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_drain: got %0d beats still pending after %0d cycles, required 0",
               name, exp_q.size(), budget);
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  function automatic int glog(input int i);
    return (g_log.size() > i) ? int'(g_log[i]) : -1;
  endfunction

  function automatic int gaplog(input int i);
    return (gap_log.size() > i) ? gap_log[i] : -1;
  endfunction

  int exp_g2 [5] = '{1, 2, 4, 8, 1};
  int k;

  initial begin
    req_i = '0; in_data_i = '0; in_valid_i = '0; in_last_i = '0; out_ready_i = 1'b1;
    hold_v = '0; prev_g = '0; req_prev = '0; tog_mode = 1'b0;
    n_vec = 0; n_err = 0; cyc = 0; beats = 0; ov_cnt = 0; to_cnt = 0; to_cyc = 0;
    drain_pops = 0; req_cyc = 0; gap_run = 0;
    fork
      bus();
    join_none

    // Outputs while reset is held
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outputs", int'({out_valid_o, out_last_o, busy_o, oversize_o, timeout_o,
                               grant_o, in_ready_o, out_data_o}), 0);
    do_reset();

    // Single source 0, 64-byte frame
    load(0, 64, 8'h11, 1'b1);
    wait_done(400, "t1");
    chk("t1_grant", glog(0), 1);
    chk("t1_latency", (g_cyc.size() > 0) ? g_cyc[0] - req_cyc : -1, 1);
    chk("t1_beats", beats, 64);
    chk("t1_gap", gaplog(0), IFG);
    chk("t1_idle", int'({busy_o, grant_o}), 0);

    // All four sources, 10-byte frames, source 0 has two queued
    do_reset();
    load(0, 10, 8'h21, 1'b1);
    load(1, 10, 8'h22, 1'b1);
    load(2, 10, 8'h23, 1'b1);
    load(3, 10, 8'h24, 1'b1);
    load(0, 10, 8'h25, 1'b1);
    wait_done(600, "t2");
    chk("t2_grants", g_log.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t2_grant%0d", i), glog(i), exp_g2[i]);
    chk("t2_gaps", gap_log.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t2_gap%0d", i), gaplog(i), IFG);
    chk("t2_beats", beats, 50);

    // Source 2, 600-byte frame under alternating backpressure
    do_reset();
    tog_mode = 1'b1;
    load(2, 600, 8'h31, 1'b1);
    wait_done(2500, "t3");
    chk("t3_grant", glog(0), 4);
    chk("t3_beats", beats, 600);
    chk("t3_timeout", to_cnt, 0);
    chk("t3_oversize", ov_cnt, 0);

    // Source 1 oversize frame, then source 2
    do_reset();
    load(1, 1600, 8'h41, 1'b1);
    load(2, 10, 8'h42, 1'b1);
    wait_done(3000, "t4");
    chk("t4_oversize", ov_cnt, 1);
    chk("t4_drain_pops", drain_pops, 78);
    chk("t4_beats", beats, 1532);
    chk("t4_grant0", glog(0), 2);
    chk("t4_grant1", glog(1), 4);

    // Source 3 granted but silent
    do_reset();
    hold_v[3] = 1'b1;
    load(3, 5, 8'h51, 1'b0);
    k = 0;
    while (to_cnt == 0 && k < 1500) begin
      @(posedge clk); #2;
      k++;
    end
    chk("t5_timeout", to_cnt, 1);
    chk("t5_timeout_cycle", (g_cyc.size() > 0) ? to_cyc - g_cyc[0] : -1, TO - 1);
    chk("t5_released", int'({busy_o, grant_o}), 16);
    src_q[3].delete();
    hold_v = '0;
    load(0, 10, 8'h52, 1'b1);
    load(1, 10, 8'h53, 1'b1);
    wait_done(500, "t5");
    chk("t5_grant0", glog(0), 8);
    chk("t5_ptr_grant", glog(1), 1);
    chk("t5_next_grant", glog(2), 2);
    chk("t5_beats", beats, 20);

    // Reset during beat 30 of source 0
    do_reset();
    load(0, 64, 8'h61, 1'b1);
    k = 0;
    while (beats < 30 && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    chk("t6_beat_at_reset", beats, 30);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", int'({out_valid_o, out_last_o, busy_o, oversize_o, timeout_o,
                                  grant_o, in_ready_o, out_data_o}), 0);
    do_reset();
    load(0, 10, 8'h62, 1'b1);
    load(1, 10, 8'h63, 1'b1);
    wait_done(400, "t6");
    chk("t6_grant0", glog(0), 1);
    chk("t6_grant1", glog(1), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
